// File: rtl/stream_sel_rr_pkg.sv
// Shared types and default sizing for the stream selector family.
package stream_sel_rr_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } sel_mode_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

endpackage

// File: rtl/stream_sel_rr_if.sv
// Producer/consumer bundle of the stream selector: N input channels, one output stream.
interface stream_sel_rr_if
    import stream_sel_rr_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    sel_mode_e          mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/stream_sel_rr_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping at N.
module rr_pick #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt,
    output logic            gnt_v
);
    localparam logic [SELW:0]   N_W  = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0] start;
    logic [SELW-1:0] first;
    logic [SELW:0]   sum;
    logic [N-1:0]    rot;

    // Explicit wrap keeps non-power-of-two N from visiting phantom channels.
    assign start = (ptr >= LAST) ? '0 : ptr + SELW'(1);

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [SELW:0]   pos_w;
        logic [SELW-1:0] pos;
        assign pos_w   = {1'b0, start} + (SELW+1)'(gi);
        assign pos     = (pos_w >= N_W) ? SELW'(pos_w - N_W) : SELW'(pos_w);
        assign rot[gi] = req[pos];
    end

    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = SELW'(i);
        end
    end

    assign sum   = {1'b0, start} + {1'b0, first};
    assign gnt   = (sum >= N_W) ? SELW'(sum - N_W) : SELW'(sum);
    assign gnt_v = |req;

endmodule

// File: rtl/stream_sel_rr.sv
// N-to-1 registered stream selector, fixed-select or round-robin, with valid/ready on both sides.
module stream_sel_rr
    import stream_sel_rr_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = DEF_N,
    localparam int SELW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_sel_rr_if.slave bus
);
    localparam logic [SELW:0]   N_W     = (SELW+1)'(N);
    localparam logic [SELW-1:0] PTR_RST = SELW'(N - 1);

    logic [WIDTH-1:0] chan_data [N];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_gnt, gnt;
    logic             rr_gnt_v, gnt_v;
    logic             load_en, take;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end

    rr_pick #(.N(N)) u_pick (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .gnt   (rr_gnt),
        .gnt_v (rr_gnt_v)
    );

    // An out-of-range select simply yields no grant.
    always_comb begin
        gnt   = bus.sel;
        gnt_v = 1'b0;
        if (bus.mode == MODE_RR) begin
            gnt   = rr_gnt;
            gnt_v = rr_gnt_v;
        end else if ({1'b0, bus.sel} < N_W) begin
            gnt_v = bus.in_valid[bus.sel];
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign take    = rst_n && load_en && gnt_v;

    always_comb begin
        bus.in_ready = '0;
        if (take) bus.in_ready[gnt] = 1'b1;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_v;
            if (gnt_v) begin
                out_data_d = chan_data[gnt];
                out_chan_d = gnt;
                ptr_d      = gnt;
            end
        end
    end

    // ptr resets to N-1 so channel 0 wins the first round-robin search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= PTR_RST;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_sel_rr.sv
// Directed bench for stream_sel_rr (N=4 and N=3) against a behavioural selector model.
module tb_stream_sel_rr;
    import stream_sel_rr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_sel_rr_if #(.N(4), .WIDTH(32)) bus4 ();
    stream_sel_rr_if #(.N(3), .WIDTH(32)) bus3 ();

    logic [31:0] d4 [4];
    logic [31:0] d3 [3];
    assign bus4.in_data = {d4[3], d4[2], d4[1], d4[0]};
    assign bus3.in_data = {d3[2], d3[1], d3[0]};

    stream_sel_rr #(.WIDTH(32), .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    stream_sel_rr #(.WIDTH(32), .N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
        $display("chk  %-14s got %h want %h", name, act, exp);
    endtask

    // Grant rule straight from the selector definition: -1 means no grant.
    function automatic int pick(input int n, input logic [15:0] v, input logic rr,
                                input int sel, input int last);
        if (!rr) return (sel < n && v[sel]) ? sel : -1;
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (last + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    logic        m4_v, m3_v;
    logic [31:0] m4_d, m3_d;
    int          m4_c, m3_c, m4_last, m3_last;
    int          g4, g3;
    logic [3:0]  er4;
    logic [2:0]  er3;

    always_comb begin
        g4  = pick(4, 16'(bus4.in_valid), bus4.mode == MODE_RR, int'(bus4.sel), m4_last);
        g3  = pick(3, 16'(bus3.in_valid), bus3.mode == MODE_RR, int'(bus3.sel), m3_last);
        er4 = (rst_n && (!m4_v || bus4.out_ready) && g4 >= 0) ? 4'(32'd1 << g4[1:0]) : 4'd0;
        er3 = (rst_n && (!m3_v || bus3.out_ready) && g3 >= 0) ? 3'(32'd1 << g3[1:0]) : 3'd0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_v <= 1'b0; m4_d <= '0; m4_c <= 0; m4_last <= 3;
            m3_v <= 1'b0; m3_d <= '0; m3_c <= 0; m3_last <= 2;
        end else begin
            if (!m4_v || bus4.out_ready) begin
                if (g4 >= 0) begin
                    m4_v <= 1'b1; m4_d <= d4[g4[1:0]]; m4_c <= g4; m4_last <= g4;
                end else m4_v <= 1'b0;
            end
            if (!m3_v || bus3.out_ready) begin
                if (g3 >= 0) begin
                    m3_v <= 1'b1; m3_d <= d3[g3[1:0]]; m3_c <= g3; m3_last <= g3;
                end else m3_v <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("m4_valid", 32'(bus4.out_valid), 32'(m4_v));
        check("m4_data",  bus4.out_data,       m4_d);
        check("m4_chan",  32'(bus4.out_chan),  32'(m4_c));
        check("m4_ready", 32'(bus4.in_ready),  32'(er4));
        check("m3_valid", 32'(bus3.out_valid), 32'(m3_v));
        check("m3_data",  bus3.out_data,       m3_d);
        check("m3_chan",  32'(bus3.out_chan),  32'(m3_c));
        check("m3_ready", 32'(bus3.in_ready),  32'(er3));
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk);     endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) d4[i] = $urandom;
        for (int i = 0; i < 3; i++) d3[i] = $urandom;
        bus4.in_valid = 4'($urandom); bus4.mode = sel_mode_e'($urandom_range(0, 1));
        bus4.sel = 2'($urandom); bus4.out_ready = 1'($urandom);
        bus3.in_valid = 3'($urandom); bus3.mode = sel_mode_e'($urandom_range(0, 1));
        bus3.sel = 2'($urandom); bus3.out_ready = 1'($urandom);

        // reset state
        step(); step(); mid();
        lit("rst_valid", 32'(bus4.out_valid), 32'd0);
        lit("rst_data",  bus4.out_data,       32'd0);
        lit("rst_chan",  32'(bus4.out_chan),  32'd0);
        lit("rst_ready", 32'(bus4.in_ready),  32'd0);
        step();
        rst_n = 1'b1; bus4.in_valid = 4'b0001; bus4.mode = MODE_RR; bus4.out_ready = 1'b1;
        bus3.in_valid = '0; bus3.out_ready = 1'b1;
        mid(); step(); mid();
        lit("rel_chan",  32'(bus4.out_chan),  32'd0);
        lit("rel_valid", 32'(bus4.out_valid), 32'd1);

        // fixed select
        step();
        bus4.mode = MODE_FIXED; bus4.sel = 2'd2; bus4.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) d4[i] = 32'hA5A5_0000 + 32'(i);
        mid();
        lit("fix_ready", 32'(bus4.in_ready), 32'h4);
        for (int i = 0; i < 4; i++) begin
            step(); mid();
            lit("fix_data",  bus4.out_data,      32'hA5A5_0002);
            lit("fix_chan",  32'(bus4.out_chan), 32'd2);
            lit("fix_ready", 32'(bus4.in_ready), 32'h4);
        end

        // round-robin fairness after a fresh reset
        step(); rst_n = 1'b0; mid();
        step();
        rst_n = 1'b1; bus4.mode = MODE_RR; bus4.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) d4[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) begin
            step(); mid();
            lit("rr_chan",  32'(bus4.out_chan),  32'(i % 4));
            lit("rr_valid", 32'(bus4.out_valid), 32'd1);
        end

        // backpressure holding ch1
        step(); bus4.in_valid = 4'b0010; mid();
        step();
        bus4.out_ready = 1'b0; bus4.in_valid = 4'b1111; d4[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            mid();
            lit("bp_data",  bus4.out_data,      32'h1000_0001);
            lit("bp_chan",  32'(bus4.out_chan), 32'd1);
            lit("bp_ready", 32'(bus4.in_ready), 32'd0);
        end
        step(); bus4.out_ready = 1'b1; mid();
        lit("bp_rel_rdy", 32'(bus4.in_ready), 32'h4);
        step(); mid();
        lit("bp_nxt_chan", 32'(bus4.out_chan),  32'd2);
        lit("bp_nxt_vld",  32'(bus4.out_valid), 32'd1);
        lit("bp_nxt_data", bus4.out_data,       32'h1000_0002);

        // sparse request wraps back to the same channel
        step(); bus4.in_valid = 4'b1000; mid();
        step(); mid();
        lit("sp_chan",  32'(bus4.out_chan), 32'd3);
        lit("sp_ready", 32'(bus4.in_ready), 32'h8);
        step(); mid();
        lit("sp_chan2", 32'(bus4.out_chan),  32'd3);
        lit("sp_vld2",  32'(bus4.out_valid), 32'd1);

        // N=3: wrap without phantom channel, then out-of-range select
        step();
        bus3.mode = MODE_RR; bus3.in_valid = 3'b111;
        for (int i = 0; i < 3; i++) d3[i] = 32'h3000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) begin
            step(); mid();
            lit("n3_rr_chan", 32'(bus3.out_chan), 32'(i % 3));
        end
        step(); bus3.mode = MODE_FIXED; bus3.sel = 2'd1; mid();
        step(); mid();
        lit("n3_fix_chan", 32'(bus3.out_chan), 32'd1);
        step(); bus3.sel = 2'd3; mid();
        lit("n3_bad_rdy", 32'(bus3.in_ready),  32'd0);
        lit("n3_bad_vld", 32'(bus3.out_valid), 32'd1);
        step(); mid();
        lit("n3_drop_vld",  32'(bus3.out_valid), 32'd0);
        lit("n3_hold_chan", 32'(bus3.out_chan),  32'd1);
        lit("n3_hold_data", bus3.out_data,       32'h3000_0001);

        // asynchronous reset mid-transfer
        step(); bus4.in_valid = 4'b1111; mid();
        step(); mid();
        lit("ar_pre_vld", 32'(bus4.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        lit("ar_vld",   32'(bus4.out_valid), 32'd0);
        lit("ar_data",  bus4.out_data,       32'd0);
        lit("ar_ready", 32'(bus4.in_ready),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        mid(); step(); mid();
        lit("ar_rr_chan", 32'(bus4.out_chan),  32'd0);
        lit("ar_rr_vld",  32'(bus4.out_valid), 32'd1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
